// File: rtl/mux_alu_pkg.sv
// Shared widths, operation codes and reset value for the mux_alu datapath leaf.
package mux_alu_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    OP_A   = 3'd0,
    OP_B   = 3'd1,
    OP_C   = 3'd2,
    OP_D   = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_AND = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  localparam logic [WIDTH:0] RST_VAL = '0;

endpackage

// File: rtl/mux_alu_core.sv
// Combinational selector/ALU: maps sel_i and operands A..D to a WIDTH+1 bit result.
module mux_alu_core
  import mux_alu_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH:0]   result
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra MSB carries the add carry-out, or the borrow of the modular subtract
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, C} - {1'b0, D};

  always_comb begin
    result = '0;
    case (op_e'(sel_i))
      OP_A:    result = {1'b0, A};
      OP_B:    result = {1'b0, B};
      OP_C:    result = {1'b0, C};
      OP_D:    result = {1'b0, D};
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_AND:  result = {1'b0, A & B};
      OP_XOR:  result = {1'b0, C ^ D};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mux_alu.sv
// Registered mux/ALU: the core result is captured into out on enabled rising edges.
module mux_alu
  import mux_alu_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             enb,
  output logic [WIDTH:0]   out
);

  logic [WIDTH:0] result;

  mux_alu_core u_core (
    .sel_i  (sel_i),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .result (result)
  );

  // Reset discards whatever was held; enb low simply keeps the last result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out <= RST_VAL;
    end else if (enb) begin
      out <= result;
    end
  end

endmodule

// File: tb/tb_mux_alu.sv
// Scoreboard bench for mux_alu: driver pushes model results, a negedge monitor pops and compares.
module tb_mux_alu;

  logic       clk;
  logic       rstn;
  logic [7:0] A, B, C, D;
  logic [2:0] sel_i;
  logic       enb;
  logic [8:0] out;

  logic [8:0] exp_q[$];
  logic [8:0] model_out;
  int         checks_total;
  int         checks_passed;

  mux_alu dut (
    .clk   (clk),
    .rstn  (rstn),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .sel_i (sel_i),
    .enb   (enb),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference written from the operation table with plain integer arithmetic
  function automatic int refResult(int sel, int a, int b, int c, int d);
    case (sel)
      0: return a;
      1: return b;
      2: return c;
      3: return d;
      4: return a + b;
      5: return (c - d + 512) % 512;
      6: return a & b;
      default: return c ^ d;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: out=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Called at negedge+1: drive inputs, let one rising edge pass, push the expected out
  task automatic applyStimulus(input logic rst_in, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d,
                               input logic [2:0] sel, input logic en);
    rstn  = rst_in;
    A     = a;
    B     = b;
    C     = c;
    D     = d;
    sel_i = sel;
    enb   = en;
    if (!rst_in) model_out = 9'h000;
    @(posedge clk);
    #1;
    if (!rst_in) model_out = 9'h000;
    else if (en) model_out = 9'(refResult(int'(sel), int'(a), int'(b), int'(c), int'(d)));
    exp_q.push_back(model_out);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput("scoreboard", out, exp_q.pop_front());
    end
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    model_out     = 9'h000;
    rstn  = 1'b0;
    A     = 8'h00;
    B     = 8'h00;
    C     = 8'h00;
    D     = 8'h00;
    sel_i = 3'd0;
    enb   = 1'b0;

    #2;
    checkOutput("reset_value", out, 9'h000);
    @(negedge clk);
    #1;

    // Reset: load nonzero, assert rstn between edges, hold in reset, release and reload
    applyStimulus(1'b1, 8'h5A, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("preload", out, 9'h05A);
    rstn = 1'b0;
    model_out = 9'h000;
    #1;
    checkOutput("reset_async", out, 9'h000);
    applyStimulus(1'b0, 8'h77, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("reset_hold", out, 9'h000);
    applyStimulus(1'b1, 8'h10, 8'h05, 8'h00, 8'h00, 3'd4, 1'b1);
    checkOutput("reset_release", out, 9'h015);

    // Pass-through sweep
    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 3'd0, 1'b1);
    checkOutput("pass_a", out, 9'h011);
    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 3'd1, 1'b1);
    checkOutput("pass_b", out, 9'h022);
    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 3'd2, 1'b1);
    checkOutput("pass_c", out, 9'h033);
    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 3'd3, 1'b1);
    checkOutput("pass_d", out, 9'h044);

    // Arithmetic and logic boundaries
    applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 3'd4, 1'b1);
    checkOutput("add_carry", out, 9'h1FE);
    applyStimulus(1'b1, 8'h10, 8'h05, 8'h00, 8'h00, 3'd4, 1'b1);
    checkOutput("add_small", out, 9'h015);
    applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 3'd5, 1'b1);
    checkOutput("sub_borrow", out, 9'h1FF);
    applyStimulus(1'b1, 8'h00, 8'h00, 8'h50, 8'h20, 3'd5, 1'b1);
    checkOutput("sub_plain", out, 9'h030);
    applyStimulus(1'b1, 8'h00, 8'h00, 8'h6B, 8'h6B, 3'd5, 1'b1);
    checkOutput("sub_equal", out, 9'h000);
    applyStimulus(1'b1, 8'hF0, 8'h3C, 8'h00, 8'h00, 3'd6, 1'b1);
    checkOutput("and", out, 9'h030);
    applyStimulus(1'b1, 8'h00, 8'h00, 8'hAA, 8'hFF, 3'd7, 1'b1);
    checkOutput("xor", out, 9'h055);

    // Enable hold: out must stay put while operands and sel_i churn
    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 3'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    3'($urandom), 1'b0);
      checkOutput("enb_hold", out, 9'h022);
    end
    applyStimulus(1'b1, 8'h01, 8'h02, 8'h03, 8'h04, 3'd4, 1'b1);
    checkOutput("enb_resume", out, 9'h003);

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    3'($urandom), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #1;
    checks_total++;
    if (exp_q.size() == 0) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
